// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: requester handshake and CDB broadcast bundle
interface cdb_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_DEPTH = 8,
  parameter int TAG_W     = 3,
  parameter int DATA_W    = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      flush;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [ROB_DEPTH-1:0]      set_rob_valid;
  logic [NUM_REQ-1:0]        held;
  modport master (
    output req_valid, req_tag, req_data, flush,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, set_rob_valid, held
  );
  modport slave (
    input  req_valid, req_tag, req_data, flush,
    output req_ready, cdb_valid, cdb_tag, cdb_data, set_rob_valid, held
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one-slot-per-requester CDB arbiter with registered broadcast; CDB_ROUND_ROBIN_EN selects round-robin over fixed priority
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_DEPTH = 8,
  parameter int TAG_W     = 3,
  parameter int DATA_W    = 32
) (
  input logic         clk,
  input logic         rst,
  cdb_arbiter_if.slave bus
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0] held, grant, acc;
  logic [TAG_W-1:0]   tag_q [NUM_REQ];
  logic [DATA_W-1:0]  data_q [NUM_REQ];
  logic [PW-1:0]      gidx;
  logic               cdb_valid;
  logic [TAG_W-1:0]   cdb_tag;
  logic [DATA_W-1:0]  cdb_data;
`ifdef CDB_ROUND_ROBIN_EN
  logic [PW-1:0] rr_ptr;
  int k;
  // first held slot at or after rr_ptr, wrapping
  always_comb begin
    grant = '0;
    gidx = '0;
    k = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      k = (int'(rr_ptr) + j) % NUM_REQ;
      if (grant == '0 && held[k]) begin
        grant[k] = 1'b1;
        gidx = PW'(k);
      end
    end
  end
  // pointer moves past the winner; a flushed grant does not count
  always_ff @(posedge clk)
    if (rst) rr_ptr <= '0;
    else if (!bus.flush && |grant) rr_ptr <= gidx == PW'(NUM_REQ-1) ? '0 : gidx + 1'b1;
`else
  // lowest held index wins
  always_comb begin
    grant = '0;
    gidx = '0;
    for (int j = 0; j < NUM_REQ; j++)
      if (grant == '0 && held[j]) begin
        grant[j] = 1'b1;
        gidx = PW'(j);
      end
  end
`endif
  assign bus.req_ready = {NUM_REQ{!rst && !bus.flush}} & (~held | grant);
  assign acc = bus.req_valid & bus.req_ready;
  // slot payload loads on accept only; occupancy lives in held
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_REQ; i++)
      if (acc[i]) begin
        tag_q[i] <= bus.req_tag[i*TAG_W +: TAG_W];
        data_q[i] <= bus.req_data[i*DATA_W +: DATA_W];
      end
  // occupancy and CDB register; a refill of the granted slot keeps it held
  always_ff @(posedge clk)
    if (rst) begin
      held <= '0;
      cdb_valid <= 1'b0;
      cdb_tag <= '0;
      cdb_data <= '0;
    end else if (bus.flush) begin
      held <= '0;
      cdb_valid <= 1'b0;
    end else begin
      held <= (held & ~grant) | acc;
      cdb_valid <= |grant;
      if (|grant) begin
        cdb_tag <= tag_q[gidx];
        cdb_data <= data_q[gidx];
      end
    end
  assign bus.cdb_valid = cdb_valid;
  assign bus.cdb_tag = cdb_tag;
  assign bus.cdb_data = cdb_data;
  assign bus.held = held;
  assign bus.set_rob_valid = cdb_valid ? ROB_DEPTH'(1) << cdb_tag : '0;
endmodule
